// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_CHECK,
        ST_RESP
    } boot_state_t;

    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [7:0] SYNC_DFLT = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_word_packer.sv
// Packs payload bytes into little-endian memory words and issues one write per
// filled (or final partial) word.
module uart_boot_loader_word_packer #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    input  logic                        last,
    output logic                        mem_wen,
    output logic [ADDR_W-1:0]           mem_wa,
    output logic [8*BYTES_PER_WORD-1:0] mem_wd,
    output logic [BYTES_PER_WORD-1:0]   mem_wmask
);
    localparam int unsigned LW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [LW-1:0]               lane;
    logic [8*BYTES_PER_WORD-1:0] word_buf, word_next;
    logic [BYTES_PER_WORD-1:0]   mask_buf, mask_next;
    logic [ADDR_W-1:0]           waddr;
    logic                        full;

    always_comb begin
        word_next              = word_buf;
        mask_next              = mask_buf;
        word_next[lane*8 +: 8] = byte_data;
        mask_next[lane]        = 1'b1;
        full                   = (lane == LW'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane      <= '0;
            word_buf  <= '0;
            mask_buf  <= '0;
            waddr     <= ADDR_W'(BASE_ADDR);
            mem_wen   <= 1'b0;
            mem_wa    <= '0;
            mem_wd    <= '0;
            mem_wmask <= '0;
        end else begin
            mem_wen <= 1'b0;
            if (clear) begin
                lane     <= '0;
                word_buf <= '0;
                mask_buf <= '0;
                waddr    <= ADDR_W'(BASE_ADDR);
            end else if (byte_valid) begin
                if (full || last) begin
                    // Partial final word carries only the lanes actually filled.
                    mem_wen   <= 1'b1;
                    mem_wa    <= waddr;
                    mem_wd    <= word_next;
                    mem_wmask <= mask_next;
                    waddr     <= waddr + ADDR_W'(BYTES_PER_WORD);
                    lane      <= '0;
                    word_buf  <= '0;
                    mask_buf  <= '0;
                end else begin
                    lane     <= lane + 1'b1;
                    word_buf <= word_next;
                    mask_buf <= mask_next;
                end
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Framed, checksummed UART image loader: writes payload to memory, holds the
// CPU in reset during transfer and answers each frame with ACK/NAK.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned MAX_BYTES      = 2048,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1_200_000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DFLT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    input  logic                        tx_ready,
    output logic                        tx_valid,
    output logic [7:0]                  tx_data,
    output logic                        mem_wen,
    output logic [ADDR_W-1:0]           mem_wa,
    output logic [8*BYTES_PER_WORD-1:0] mem_wd,
    output logic [BYTES_PER_WORD-1:0]   mem_wmask,
    output logic                        cpu_reset_n,
    output logic                        busy,
    output logic                        boot_ok,
    output logic                        boot_err
);
    boot_state_t state;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [15:0] new_len;
    logic [7:0]  sum;
    logic [31:0] tcnt;
    logic        resp_ack;
    logic        armed;
    logic        in_frame;
    logic        timeout;
    logic        pk_valid;
    logic        pk_last;
    logic        pk_clear;

    always_comb begin
        new_len  = {rx_data, len[7:0]};
        in_frame = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                   (state == ST_PAYLOAD) || (state == ST_CHECK);
        timeout  = in_frame && !rx_valid && (tcnt == TIMEOUT_CYCLES - 1);
        pk_valid = (state == ST_PAYLOAD) && rx_valid;
        pk_last  = (cnt == len - 16'd1);
        pk_clear = (state == ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    end

    uart_boot_loader_word_packer #(
        .BYTES_PER_WORD(BYTES_PER_WORD),
        .ADDR_W        (ADDR_W),
        .BASE_ADDR     (BASE_ADDR)
    ) u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (pk_clear),
        .byte_valid(pk_valid),
        .byte_data (rx_data),
        .last      (pk_last),
        .mem_wen   (mem_wen),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .mem_wmask (mem_wmask)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            len         <= '0;
            cnt         <= '0;
            sum         <= '0;
            tcnt        <= '0;
            resp_ack    <= 1'b0;
            armed       <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b0;
            boot_ok     <= 1'b0;
            boot_err    <= 1'b0;
        end else begin
            // Release the CPU once after reset; a SYNC on the same edge wins.
            if (!armed) begin
                armed       <= 1'b1;
                cpu_reset_n <= 1'b1;
            end
            if (rx_valid || !in_frame) tcnt <= '0;
            else                       tcnt <= tcnt + 32'd1;

            if (timeout) begin
                state    <= ST_RESP;
                tx_valid <= 1'b1;
                tx_data  <= NAK_BYTE;
                resp_ack <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (pk_clear) begin
                        state       <= ST_LEN_LO;
                        cpu_reset_n <= 1'b0;
                        busy        <= 1'b1;
                        boot_ok     <= 1'b0;
                        boot_err    <= 1'b0;
                        sum         <= '0;
                        cnt         <= '0;
                    end
                    ST_LEN_LO: if (rx_valid) begin
                        len[7:0] <= rx_data;
                        state    <= ST_LEN_HI;
                    end
                    ST_LEN_HI: if (rx_valid) begin
                        len <= new_len;
                        if (new_len > 16'(MAX_BYTES)) begin
                            state    <= ST_RESP;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK_BYTE;
                            resp_ack <= 1'b0;
                        end else if (new_len == 16'd0) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: if (rx_valid) begin
                        sum <= sum + rx_data;
                        cnt <= cnt + 16'd1;
                        if (pk_last) state <= ST_CHECK;
                    end
                    ST_CHECK: if (rx_valid) begin
                        state    <= ST_RESP;
                        tx_valid <= 1'b1;
                        tx_data  <= (rx_data == sum) ? ACK_BYTE : NAK_BYTE;
                        resp_ack <= (rx_data == sum);
                    end
                    ST_RESP: if (tx_ready) begin
                        state    <= ST_IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        if (resp_ack) begin
                            boot_ok     <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            boot_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
